hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage ARM pipelined datapath.
- Consumes the datapath's register-match flags and the decode-stage control bits. Produces the forwarding selects and the stall and flush controls that the datapath consumes.
- Keeps its own E/M/W shadow pipeline of the hazard-relevant control bits (RegWrite, MemtoReg, PCSrc), so it does not depend on the controller's pipeline registers.
- Includes saturating performance counters for load-use stalls and branch flushes.

---
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage ARM pipeline: forwarding selects, stall/flush controls,
// a private E/M/W shadow of the hazard-relevant control bits and saturating event counters.
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Match_1E_M,
  input  logic             Match_1E_W,
  input  logic             Match_2E_M,
  input  logic             Match_2E_W,
  input  logic             Match_12D_E,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             BranchTakenE,
  input  logic             ClrCnt,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] LdStallCnt,
  output logic [CNT_W-1:0] BrFlushCnt
);

  localparam logic [1:0] FwdRd1    = 2'b00;
  localparam logic [1:0] FwdResult = 2'b01;
  localparam logic [1:0] FwdAluOut = 2'b10;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Shadow pipeline of control bits
  logic reg_write_e, mem_to_reg_e, pc_src_e;
  logic reg_write_m, mem_to_reg_m, pc_src_m;
  logic reg_write_w, pc_src_w;

  logic ld_stall;
  logic pc_wr_pending;

  logic [CNT_W-1:0] ld_stall_cnt_q, ld_stall_cnt_d;
  logic [CNT_W-1:0] br_flush_cnt_q, br_flush_cnt_d;

  // Forwarding: the M-stage result is younger than W, so it wins when both match
  always_comb begin
    ForwardAE = FwdRd1;
    if (Match_1E_M && reg_write_m) begin
      ForwardAE = FwdAluOut;
    end else if (Match_1E_W && reg_write_w) begin
      ForwardAE = FwdResult;
    end
  end

  always_comb begin
    ForwardBE = FwdRd1;
    if (Match_2E_M && reg_write_m) begin
      ForwardBE = FwdAluOut;
    end else if (Match_2E_W && reg_write_w) begin
      ForwardBE = FwdResult;
    end
  end

  always_comb begin
    ld_stall      = Match_12D_E & mem_to_reg_e & reg_write_e;
    pc_wr_pending = PCSrcD | pc_src_e | pc_src_m;
    StallF        = ld_stall | pc_wr_pending;
    StallD        = ld_stall;
    FlushD        = pc_wr_pending | pc_src_w | BranchTakenE;
    FlushE        = ld_stall | BranchTakenE;
  end

  // E bits are never held by StallD: a load-use stall always flushes E instead
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      pc_src_e     <= 1'b0;
    end else if (FlushE) begin
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      pc_src_e     <= 1'b0;
    end else begin
      reg_write_e  <= RegWriteD;
      mem_to_reg_e <= MemtoRegD;
      pc_src_e     <= PCSrcD;
    end
  end

  // Writes from a failed-condition instruction are squashed on entry to M
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pc_src_m     <= 1'b0;
      reg_write_w  <= 1'b0;
      pc_src_w     <= 1'b0;
    end else begin
      reg_write_m  <= reg_write_e & CondExE;
      mem_to_reg_m <= mem_to_reg_e;
      pc_src_m     <= pc_src_e & CondExE;
      reg_write_w  <= reg_write_m;
      pc_src_w     <= pc_src_m;
    end
  end

  always_comb begin
    ld_stall_cnt_d = ld_stall_cnt_q;
    br_flush_cnt_d = br_flush_cnt_q;
    if (ClrCnt) begin
      ld_stall_cnt_d = '0;
      br_flush_cnt_d = '0;
    end else begin
      if (ld_stall && (ld_stall_cnt_q != CntMax)) begin
        ld_stall_cnt_d = ld_stall_cnt_q + 1'b1;
      end
      if (BranchTakenE && (br_flush_cnt_q != CntMax)) begin
        br_flush_cnt_d = br_flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_stall_cnt_q <= '0;
      br_flush_cnt_q <= '0;
    end else begin
      ld_stall_cnt_q <= ld_stall_cnt_d;
      br_flush_cnt_q <= br_flush_cnt_d;
    end
  end

  assign LdStallCnt = ld_stall_cnt_q;
  assign BrFlushCnt = br_flush_cnt_q;

  // MemtoRegM is tracked for completeness of the shadow pipeline but drives no output
  logic unused_mem_to_reg_m;
  assign unused_mem_to_reg_m = mem_to_reg_m;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default-width instance plus a CNT_W=2 instance
// sharing the same stimulus for the counter saturation checks.
module tb_hazard_unit;

  logic clk, reset;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE, ClrCnt;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [15:0] LdStallCnt, BrFlushCnt;

  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic       s_StallF, s_StallD, s_FlushD, s_FlushE;
  logic [1:0] s_LdStallCnt, s_BrFlushCnt;

  int n_checks;
  int n_fail;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .ClrCnt(ClrCnt),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .LdStallCnt(LdStallCnt), .BrFlushCnt(BrFlushCnt)
  );

  hazard_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .ClrCnt(ClrCnt),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .LdStallCnt(s_LdStallCnt), .BrFlushCnt(s_BrFlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Match_1E_M = 0; Match_1E_W = 0; Match_2E_M = 0; Match_2E_W = 0; Match_12D_E = 0;
    RegWriteD = 0; MemtoRegD = 0; PCSrcD = 0; CondExE = 0; BranchTakenE = 0; ClrCnt = 0;
  endtask

  logic exp_stallf [5];
  logic exp_flushd [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    #1;

    // Reset state with idle inputs
    check_eq("rst_fwda",  {30'd0, ForwardAE}, 32'd0);
    check_eq("rst_fwdb",  {30'd0, ForwardBE}, 32'd0);
    check_eq("rst_ctrl",  {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    check_eq("rst_ldcnt", {16'd0, LdStallCnt}, 32'd0);
    check_eq("rst_brcnt", {16'd0, BrFlushCnt}, 32'd0);

    // Load-use hazard
    RegWriteD = 1; MemtoRegD = 1;
    #1;
    check_eq("ld_dcycle_ctrl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    step();
    RegWriteD = 0; MemtoRegD = 0; Match_12D_E = 1;
    #1;
    check_eq("ld_stall_ctrl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'b1101);
    step();
    check_eq("ld_cnt", {16'd0, LdStallCnt}, 32'd1);
    check_eq("ld_after_ctrl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    Match_12D_E = 0;

    // Build RegWriteM = RegWriteW = 1
    RegWriteD = 1;
    step();
    CondExE = 1;
    step();
    step();
    RegWriteD = 0;
    Match_1E_M = 1; Match_1E_W = 1; Match_2E_M = 1; Match_2E_W = 0;
    #1;
    check_eq("fwd_a_both", {30'd0, ForwardAE}, 32'd2);
    check_eq("fwd_b_m",    {30'd0, ForwardBE}, 32'd2);
    Match_1E_M = 0; Match_2E_M = 0; Match_2E_W = 1;
    #1;
    check_eq("fwd_a_w", {30'd0, ForwardAE}, 32'd1);
    check_eq("fwd_b_w", {30'd0, ForwardBE}, 32'd1);
    // E holds RegWrite=1; failed condition must keep it out of M
    CondExE = 0;
    Match_1E_M = 0; Match_1E_W = 0; Match_2E_M = 0; Match_2E_W = 0;
    step();
    Match_1E_M = 1;
    #1;
    check_eq("fwd_a_cond_fail", {30'd0, ForwardAE}, 32'd0);
    Match_1E_M = 0; Match_1E_W = 1;
    #1;
    check_eq("fwd_a_w_still", {30'd0, ForwardAE}, 32'd1);
    Match_1E_W = 0;
    step();
    step();

    // PC write: StallF for D,E,M; FlushD for D,E,M,W
    exp_stallf = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_flushd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    PCSrcD = 1; CondExE = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("pc_stallf_%0d", i), {31'd0, StallF}, {31'd0, exp_stallf[i]});
      check_eq($sformatf("pc_flushd_%0d", i), {31'd0, FlushD}, {31'd0, exp_flushd[i]});
      check_eq($sformatf("pc_flushe_%0d", i), {31'd0, FlushE}, 32'd0);
      step();
      PCSrcD = 0;
    end
    CondExE = 0;

    // Branch taken, with a load in D that the flush must discard
    BranchTakenE = 1; RegWriteD = 1; MemtoRegD = 1;
    #1;
    check_eq("br_flush", {30'd0, FlushD, FlushE}, 32'b11);
    step();
    BranchTakenE = 0; RegWriteD = 0; MemtoRegD = 0; Match_12D_E = 1;
    #1;
    check_eq("br_e_zeroed", {31'd0, StallD}, 32'd0);
    check_eq("br_cnt",   {16'd0, BrFlushCnt}, 32'd1);
    check_eq("br_cnt_s", {30'd0, s_BrFlushCnt}, 32'd1);
    Match_12D_E = 0;

    // Saturation of the 2-bit counter
    BranchTakenE = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("sat_s_%0d", i), {30'd0, s_BrFlushCnt}, (i == 0) ? 32'd2 : 32'd3);
    end
    check_eq("sat_wide", {16'd0, BrFlushCnt}, 32'd6);
    ClrCnt = 1;
    step();
    check_eq("clr_s",    {30'd0, s_BrFlushCnt}, 32'd0);
    check_eq("clr_wide", {16'd0, BrFlushCnt}, 32'd0);
    check_eq("clr_ld",   {16'd0, LdStallCnt}, 32'd0);
    ClrCnt = 0; BranchTakenE = 0;
    step();
    check_eq("after_clr", {16'd0, BrFlushCnt}, 32'd0);

    // Asynchronous reset in the middle of a PC write
    PCSrcD = 1; CondExE = 1;
    step();
    PCSrcD = 0;
    #1;
    check_eq("pre_rst_stallf", {31'd0, StallF}, 32'd1);
    reset = 1;
    #1;
    check_eq("mid_rst_ctrl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    step();
    reset = 0;
    CondExE = 0;
    #1;
    check_eq("post_rst_ctrl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
